// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding for the ALU.
// Produces forwarded ALU operands, store data and the registered downstream controls.
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            id_valid_i,
    input  logic [2:0]      id_ctl_i,
    input  logic [XLEN-1:0] id_rs1_data_i,
    input  logic [XLEN-1:0] id_rs2_data_i,
    input  logic [XLEN-1:0] id_imm_i,
    input  logic            id_alu_src_i,
    input  logic [RA_W-1:0] id_rs1_i,
    input  logic [RA_W-1:0] id_rs2_i,
    input  logic [RA_W-1:0] id_rd_i,
    input  logic            id_reg_write_i,
    input  logic            id_mem_read_i,
    input  logic            id_mem_write_i,
    input  logic            id_mem_to_reg_i,
    input  logic            exmem_reg_write_i,
    input  logic [RA_W-1:0] exmem_rd_i,
    input  logic [XLEN-1:0] exmem_result_i,
    input  logic            memwb_reg_write_i,
    input  logic [RA_W-1:0] memwb_rd_i,
    input  logic [XLEN-1:0] memwb_result_i,
    output logic [XLEN-1:0] alu_op1_o,
    output logic [XLEN-1:0] alu_op2_o,
    output logic [2:0]      alu_ctl_o,
    output logic [XLEN-1:0] store_data_o,
    output logic            ex_valid_o,
    output logic [RA_W-1:0] ex_rd_o,
    output logic            ex_reg_write_o,
    output logic            ex_mem_read_o,
    output logic            ex_mem_write_o,
    output logic            ex_mem_to_reg_o,
    output logic [1:0]      fwd_a_o,
    output logic [1:0]      fwd_b_o
);

    logic                   vld_p1;
    logic [2:0]             ctl_p1;
    logic [RA_W-1:0]        rs1_p1, rs2_p1, rd_p1;
    logic                   reg_write_p1, mem_read_p1, mem_write_p1, mem_to_reg_p1;
    logic                   alu_src_p1;
    logic signed [XLEN-1:0] rs1_data_p1, rs2_data_p1, imm_p1;
    logic signed [XLEN-1:0] fwd_a_data, fwd_b_data;
    logic                   bubble;

    // Newest producer wins; x0 is hard-wired zero so it never forwards.
    function automatic logic [1:0] fwd_sel(input logic            ex_rw,
                                           input logic [RA_W-1:0] ex_rd,
                                           input logic            wb_rw,
                                           input logic [RA_W-1:0] wb_rd,
                                           input logic [RA_W-1:0] rs);
        if (ex_rw && (ex_rd != '0) && (ex_rd == rs))
            return 2'd2;
        else if (wb_rw && (wb_rd != '0) && (wb_rd == rs))
            return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic signed [XLEN-1:0] fwd_mux(input logic [1:0]             sel,
                                                       input logic signed [XLEN-1:0] reg_val,
                                                       input logic signed [XLEN-1:0] wb_val,
                                                       input logic signed [XLEN-1:0] ex_val);
        case (sel)
            2'd2:    return ex_val;
            2'd1:    return wb_val;
            default: return reg_val;
        endcase
    endfunction

    assign bubble = flush_i || !id_valid_i;

    // ID -> EX stage boundary
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vld_p1        <= 1'b0;
            ctl_p1        <= '0;
            rs1_p1        <= '0;
            rs2_p1        <= '0;
            rd_p1         <= '0;
            reg_write_p1  <= 1'b0;
            mem_read_p1   <= 1'b0;
            mem_write_p1  <= 1'b0;
            mem_to_reg_p1 <= 1'b0;
            alu_src_p1    <= 1'b0;
            rs1_data_p1   <= '0;
            rs2_data_p1   <= '0;
            imm_p1        <= '0;
        end else if (flush_i || !stall_i) begin
            vld_p1        <= !bubble;
            ctl_p1        <= bubble ? 3'd0 : id_ctl_i;
            rs1_p1        <= bubble ? '0 : id_rs1_i;
            rs2_p1        <= bubble ? '0 : id_rs2_i;
            reg_write_p1  <= !bubble && id_reg_write_i;
            mem_read_p1   <= !bubble && id_mem_read_i;
            mem_write_p1  <= !bubble && id_mem_write_i;
            mem_to_reg_p1 <= !bubble && id_mem_to_reg_i;
            rd_p1         <= id_rd_i;
            alu_src_p1    <= id_alu_src_i;
            rs1_data_p1   <= id_rs1_data_i;
            rs2_data_p1   <= id_rs2_data_i;
            imm_p1        <= id_imm_i;
        end
    end

    // EX stage: combinational forwarding on the held register contents
    always_comb begin
        fwd_a_o    = fwd_sel(exmem_reg_write_i, exmem_rd_i, memwb_reg_write_i, memwb_rd_i, rs1_p1);
        fwd_b_o    = fwd_sel(exmem_reg_write_i, exmem_rd_i, memwb_reg_write_i, memwb_rd_i, rs2_p1);
        fwd_a_data = fwd_mux(fwd_a_o, rs1_data_p1, memwb_result_i, exmem_result_i);
        fwd_b_data = fwd_mux(fwd_b_o, rs2_data_p1, memwb_result_i, exmem_result_i);
    end

    assign alu_op1_o       = fwd_a_data;
    assign alu_op2_o       = alu_src_p1 ? imm_p1 : fwd_b_data;
    assign store_data_o    = fwd_b_data;
    assign alu_ctl_o       = ctl_p1;
    assign ex_valid_o      = vld_p1;
    assign ex_rd_o         = rd_p1;
    assign ex_reg_write_o  = reg_write_p1;
    assign ex_mem_read_o   = mem_read_p1;
    assign ex_mem_write_o  = mem_write_p1;
    assign ex_mem_to_reg_o = mem_to_reg_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table for load/forwarding plus
// hand-written reset, stall and flush sequences.
module tb_id_ex_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i, flush_i, id_valid_i;
    logic [2:0]  id_ctl_i;
    logic [31:0] id_rs1_data_i, id_rs2_data_i, id_imm_i;
    logic        id_alu_src_i;
    logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
    logic        id_reg_write_i, id_mem_read_i, id_mem_write_i, id_mem_to_reg_i;
    logic        exmem_reg_write_i;
    logic [4:0]  exmem_rd_i;
    logic [31:0] exmem_result_i;
    logic        memwb_reg_write_i;
    logic [4:0]  memwb_rd_i;
    logic [31:0] memwb_result_i;
    logic [31:0] alu_op1_o, alu_op2_o, store_data_o;
    logic [2:0]  alu_ctl_o;
    logic        ex_valid_o;
    logic [4:0]  ex_rd_o;
    logic        ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o;
    logic [1:0]  fwd_a_o, fwd_b_o;

    int tests = 0;
    int fails = 0;

    id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .id_ctl_i(id_ctl_i),
        .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i),
        .id_alu_src_i(id_alu_src_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
        .id_reg_write_i(id_reg_write_i), .id_mem_read_i(id_mem_read_i),
        .id_mem_write_i(id_mem_write_i), .id_mem_to_reg_i(id_mem_to_reg_i),
        .exmem_reg_write_i(exmem_reg_write_i), .exmem_rd_i(exmem_rd_i), .exmem_result_i(exmem_result_i),
        .memwb_reg_write_i(memwb_reg_write_i), .memwb_rd_i(memwb_rd_i), .memwb_result_i(memwb_result_i),
        .alu_op1_o(alu_op1_o), .alu_op2_o(alu_op2_o), .alu_ctl_o(alu_ctl_o), .store_data_o(store_data_o),
        .ex_valid_o(ex_valid_o), .ex_rd_o(ex_rd_o), .ex_reg_write_o(ex_reg_write_o),
        .ex_mem_read_o(ex_mem_read_o), .ex_mem_write_o(ex_mem_write_o), .ex_mem_to_reg_o(ex_mem_to_reg_o),
        .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        valid;
        logic [2:0]  ctl;
        logic [4:0]  rs1, rs2, rd;
        logic        rw, src;
        logic [31:0] rs1d, rs2d, imm;
        logic        exrw;
        logic [4:0]  exrd;
        logic [31:0] exres;
        logic        wbrw;
        logic [4:0]  wbrd;
        logic [31:0] wbres;
        logic [31:0] e_op1, e_op2, e_st;
        logic [2:0]  e_ctl;
        logic [1:0]  e_fa, e_fb;
        logic        e_vld, e_rw;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        stall_i = 1'b0; flush_i = 1'b0; id_valid_i = 1'b0; id_ctl_i = 3'd0;
        id_rs1_data_i = '0; id_rs2_data_i = '0; id_imm_i = '0; id_alu_src_i = 1'b0;
        id_rs1_i = '0; id_rs2_i = '0; id_rd_i = '0;
        id_reg_write_i = 1'b0; id_mem_read_i = 1'b0; id_mem_write_i = 1'b0; id_mem_to_reg_i = 1'b0;
        exmem_reg_write_i = 1'b0; exmem_rd_i = '0; exmem_result_i = '0;
        memwb_reg_write_i = 1'b0; memwb_rd_i = '0; memwb_result_i = '0;
    endtask

    initial begin
        // valid ctl rs1 rs2 rd rw src rs1d rs2d imm | exrw exrd exres | wbrw wbrd wbres | op1 op2 st ctl fa fb vld rw
        vecs[0] = '{1'b1, 3'd4, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'hA, 32'h3, 32'h0,
                    1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                    32'hA, 32'h3, 32'h3, 3'd4, 2'd0, 2'd0, 1'b1, 1'b1};
        vecs[1] = '{1'b1, 3'd3, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 32'h100, 32'h200, 32'h0,
                    1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22,
                    32'h11, 32'h11, 32'h11, 3'd3, 2'd2, 2'd2, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 3'd3, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 32'h100, 32'h200, 32'h0,
                    1'b0, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22,
                    32'h22, 32'h22, 32'h22, 3'd3, 2'd1, 2'd1, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 3'd3, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 32'h100, 32'h200, 32'h0,
                    1'b1, 5'd0, 32'h11, 1'b1, 5'd0, 32'h22,
                    32'h100, 32'h200, 32'h200, 3'd3, 2'd0, 2'd0, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 3'd3, 5'd1, 5'd7, 5'd8, 1'b1, 1'b1, 32'h1, 32'h55, 32'hFFFFFFFC,
                    1'b1, 5'd7, 32'h99, 1'b0, 5'd0, 32'h0,
                    32'h1, 32'hFFFFFFFC, 32'h99, 3'd3, 2'd0, 2'd2, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 3'd5, 5'd3, 5'd4, 5'd10, 1'b1, 1'b0, 32'h3000, 32'h4000, 32'h0,
                    1'b1, 5'd4, 32'h44, 1'b1, 5'd3, 32'h33,
                    32'h33, 32'h44, 32'h44, 3'd5, 2'd1, 2'd2, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 3'd3, 5'd5, 5'd6, 5'd2, 1'b1, 1'b0, 32'h5A, 32'h6B, 32'h0,
                    1'b1, 5'd5, 32'h77, 1'b1, 5'd6, 32'h88,
                    32'h5A, 32'h6B, 32'h6B, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 3'd1, 5'd9, 5'd9, 5'd4, 1'b0, 1'b0, 32'h90, 32'h91, 32'h0,
                    1'b1, 5'd8, 32'hE8, 1'b1, 5'd9, 32'h9,
                    32'h9, 32'h9, 32'h9, 3'd1, 2'd1, 2'd1, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 3'd2, 5'd9, 5'd9, 5'd4, 1'b1, 1'b0, 32'h90, 32'h91, 32'h0,
                    1'b0, 5'd9, 32'hE8, 1'b0, 5'd9, 32'h9,
                    32'h90, 32'h91, 32'h91, 3'd2, 2'd0, 2'd0, 1'b1, 1'b1};

        clear_inputs();
        rst_i = 1'b0;
        #2;
        check("por_valid", {31'd0, ex_valid_o}, 32'd0);
        check("por_op1", alu_op1_o, 32'd0);
        #10 rst_i = 1'b1;

        foreach (vecs[i]) begin
            id_valid_i = vecs[i].valid; id_ctl_i = vecs[i].ctl;
            id_rs1_i = vecs[i].rs1; id_rs2_i = vecs[i].rs2; id_rd_i = vecs[i].rd;
            id_reg_write_i = vecs[i].rw; id_alu_src_i = vecs[i].src;
            id_rs1_data_i = vecs[i].rs1d; id_rs2_data_i = vecs[i].rs2d; id_imm_i = vecs[i].imm;
            exmem_reg_write_i = vecs[i].exrw; exmem_rd_i = vecs[i].exrd; exmem_result_i = vecs[i].exres;
            memwb_reg_write_i = vecs[i].wbrw; memwb_rd_i = vecs[i].wbrd; memwb_result_i = vecs[i].wbres;
            step();
            check($sformatf("v%0d_op1", i), alu_op1_o, vecs[i].e_op1);
            check($sformatf("v%0d_op2", i), alu_op2_o, vecs[i].e_op2);
            check($sformatf("v%0d_store", i), store_data_o, vecs[i].e_st);
            check($sformatf("v%0d_ctl", i), {29'd0, alu_ctl_o}, {29'd0, vecs[i].e_ctl});
            check($sformatf("v%0d_fwd_a", i), {30'd0, fwd_a_o}, {30'd0, vecs[i].e_fa});
            check($sformatf("v%0d_fwd_b", i), {30'd0, fwd_b_o}, {30'd0, vecs[i].e_fb});
            check($sformatf("v%0d_valid", i), {31'd0, ex_valid_o}, {31'd0, vecs[i].e_vld});
            check($sformatf("v%0d_reg_write", i), {31'd0, ex_reg_write_o}, {31'd0, vecs[i].e_rw});
        end

        // Reset asserted between edges clears outputs without a clock edge.
        clear_inputs();
        id_valid_i = 1'b1; id_ctl_i = 3'd3; id_rs1_data_i = 32'h5;
        step();
        check("rst_pre_op1", alu_op1_o, 32'h5);
        check("rst_pre_ctl", {29'd0, alu_ctl_o}, 32'd3);
        #1 rst_i = 1'b0;
        #1;
        check("rst_async_op1", alu_op1_o, 32'd0);
        check("rst_async_ctl", {29'd0, alu_ctl_o}, 32'd0);
        check("rst_async_valid", {31'd0, ex_valid_o}, 32'd0);
        step();
        check("rst_held_op1", alu_op1_o, 32'd0);
        #2 rst_i = 1'b1;
        #1;
        check("rst_release_valid", {31'd0, ex_valid_o}, 32'd0);
        step();
        check("rst_reload_op1", alu_op1_o, 32'h5);
        check("rst_reload_valid", {31'd0, ex_valid_o}, 32'd1);

        // Stall holds everything while forwarding keeps tracking EX/MEM.
        clear_inputs();
        id_valid_i = 1'b1; id_ctl_i = 3'd6; id_rs1_i = 5'd5; id_rs1_data_i = 32'h10;
        id_rd_i = 5'd31; id_mem_read_i = 1'b1; id_mem_write_i = 1'b1; id_mem_to_reg_i = 1'b1;
        exmem_reg_write_i = 1'b1; exmem_rd_i = 5'd5; exmem_result_i = 32'h11;
        step();
        check("ld_op1", alu_op1_o, 32'h11);
        check("ld_rd", {27'd0, ex_rd_o}, 32'd31);
        check("ld_mem_read", {31'd0, ex_mem_read_o}, 32'd1);
        check("ld_mem_write", {31'd0, ex_mem_write_o}, 32'd1);
        check("ld_mem_to_reg", {31'd0, ex_mem_to_reg_o}, 32'd1);
        stall_i = 1'b1;
        id_ctl_i = 3'd1; id_rs1_i = 5'd2; id_rs1_data_i = 32'hFF; id_rd_i = 5'd1; id_mem_read_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("stall%0d_ctl", c), {29'd0, alu_ctl_o}, 32'd6);
            check($sformatf("stall%0d_rd", c), {27'd0, ex_rd_o}, 32'd31);
            check($sformatf("stall%0d_mem_read", c), {31'd0, ex_mem_read_o}, 32'd1);
        end
        exmem_result_i = 32'h77;
        #1;
        check("stall_fwd_track", alu_op1_o, 32'h77);
        check("stall_fwd_a", {30'd0, fwd_a_o}, 32'd2);
        exmem_reg_write_i = 1'b0;
        #1;
        check("stall_regfile", alu_op1_o, 32'h10);

        // Flush together with stall inserts a bubble.
        clear_inputs();
        id_valid_i = 1'b1; id_ctl_i = 3'd3; id_rd_i = 5'd9; id_reg_write_i = 1'b1;
        id_rs1_i = 5'd5; id_rs2_i = 5'd5;
        exmem_reg_write_i = 1'b1; exmem_rd_i = 5'd5; exmem_result_i = 32'h55;
        flush_i = 1'b1; stall_i = 1'b1;
        step();
        check("flush_valid", {31'd0, ex_valid_o}, 32'd0);
        check("flush_reg_write", {31'd0, ex_reg_write_o}, 32'd0);
        check("flush_ctl", {29'd0, alu_ctl_o}, 32'd0);
        check("flush_fwd_a", {30'd0, fwd_a_o}, 32'd0);
        check("flush_fwd_b", {30'd0, fwd_b_o}, 32'd0);
        flush_i = 1'b0; stall_i = 1'b0;
        step();
        check("post_flush_valid", {31'd0, ex_valid_o}, 32'd1);
        check("post_flush_fwd_a", {30'd0, fwd_a_o}, 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
